vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; successor to the fixed 640x480 timer.
- Generalised to any mode via porch, sync and active parameters, selectable sync polarity and a configurable pixel-clock divider.
- Adds async reset, a run enable, per-pixel strobe and line/frame start pulses.
- Sits between the board clock and the pixel painter; the painter samples coordinates on `pix_en`.

---
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: clock divider, h/v raster counters
// and fully registered sync, blanking, coordinate and strobe outputs.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          HS,
  output logic          VS,
  output logic          isActive,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_en,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEGIN  = H_ACTIVE + H_FP;
  localparam int HS_END    = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEGIN  = V_ACTIVE + V_FP;
  localparam int VS_END    = V_ACTIVE + V_FP + V_SYNC;
  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;
  logic [XW-1:0] h;
  logic [YW-1:0] v;

  logic tick;
  logic h_last;
  logic v_last;
  logic h_sync_zone;
  logic v_sync_zone;
  logic visible;

  // Decode is done on the next-coordinate counters; the registers below turn
  // it into pin-level outputs, so nothing combinational reaches a pin.
  assign tick        = en && (div == DW'(CLK_DIV - 1));
  assign h_last      = (32'(h) == 32'(H_TOTAL - 1));
  assign v_last      = (32'(v) == 32'(V_TOTAL - 1));
  assign h_sync_zone = (32'(h) >= 32'(HS_BEGIN)) && (32'(h) < 32'(HS_END));
  assign v_sync_zone = (32'(v) >= 32'(VS_BEGIN)) && (32'(v) < 32'(VS_END));
  assign visible     = (32'(h) < 32'(H_ACTIVE)) && (32'(v) < 32'(V_ACTIVE));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (!en || tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + YW'(1);
      end else begin
        h <= h + XW'(1);
      end
    end
  end

  // All outputs load together from the same (h,v) so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      isActive    <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (tick) begin
      HS          <= h_sync_zone ? HS_POL : ~HS_POL;
      VS          <= v_sync_zone ? VS_POL : ~VS_POL;
      isActive    <= visible;
      pix_x       <= h;
      pix_y       <= v;
      pix_en      <= 1'b1;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
    end else begin
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen in a reduced 15x8 raster mode,
// plus a second instance with CLK_DIV=1 and active-high syncs.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, rst1_n, en1;
  logic       hs, vs, act, pe, ls, fs;
  logic [9:0] px, py;
  logic       hs1, vs1, act1, pe1, ls1, fs1;
  logic [9:0] px1, py1;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .XW(10), .YW(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .HS(hs), .VS(vs), .isActive(act),
    .pix_x(px), .pix_y(py), .pix_en(pe), .line_start(ls), .frame_start(fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .XW(10), .YW(10)
  ) dut1 (
    .clk(clk), .rst_n(rst1_n), .en(en1), .HS(hs1), .VS(vs1), .isActive(act1),
    .pix_x(px1), .pix_y(py1), .pix_en(pe1), .line_start(ls1), .frame_start(fs1)
  );

  int checks = 0;
  int passed = 0;
  int cx = 0;
  int cy = 0;

  // {pix_x, pix_y, isActive, HS, VS, line_start, frame_start}
  localparam logic [24:0] RESET_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  function automatic logic [24:0] model(int x, int y, bit pol);
    logic a, h, v;
    a = (x < 8) && (y < 4);
    h = (x >= 10 && x <= 12) ? pol : ~pol;
    v = (y >= 5 && y <= 6) ? pol : ~pol;
    return {10'(x), 10'(y), a, h, v, (x == 0), (x == 0 && y == 0)};
  endfunction

  function automatic logic [24:0] obs0();
    return {px, py, act, hs, vs, ls, fs};
  endfunction

  function automatic logic [24:0] obs1();
    return {px1, py1, act1, hs1, vs1, ls1, fs1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until pix_en is seen; n = clks taken, or -1 if none within budget.
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (pe === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic void advance();
    cx = cx + 1;
    if (cx == 15) begin
      cx = 0;
      cy = (cy + 1) % 8;
    end
  endfunction

  task automatic tick_and_check(string name);
    int n;
    advance();
    wait_tick(n);
    checks++;
    if (n !== 2 || obs0() !== model(cx, cy, 1'b0))
      $display("FAIL %s: clks=%0d got %h expected clks=2 %h (x=%0d y=%0d)",
               name, n, obs0(), model(cx, cy, 1'b0), cx, cy);
    else passed++;
  endtask

  task automatic after_release();
    int n;
    wait_tick(n);
    checks++;
    if (n !== 2 || pe !== 1'b1 || obs0() !== model(0, 0, 1'b0))
      $display("FAIL first_tick: clks=%0d got %h expected clks=2 %h", n, obs0(), model(0, 0, 1'b0));
    else passed++;
    cx = 0;
    cy = 0;
    tick_and_check("second_tick");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    step();
    checks++;
    if (obs0() !== RESET_VEC || pe !== 1'b0)
      $display("FAIL reset_state: got %h pix_en=%b expected %h pix_en=0", obs0(), pe, RESET_VEC);
    else passed++;
    rst_n = 1'b1;
    after_release();
  endtask

  task automatic test_line();
    for (int x = 2; x <= 15; x++) tick_and_check("line");
    checks++;
    if (px !== 10'd0 || py !== 10'd1 || ls !== 1'b1 || fs !== 1'b0)
      $display("FAIL line_wrap: got x=%0d y=%0d ls=%b fs=%b expected x=0 y=1 ls=1 fs=0", px, py, ls, fs);
    else passed++;
  endtask

  task automatic test_frames();
    int fs_cnt = 0;
    for (int i = 0; i < 240; i++) begin
      tick_and_check("frames");
      if (fs === 1'b1) fs_cnt++;
    end
    checks++;
    if (fs_cnt !== 2)
      $display("FAIL frame_start_count: got %0d expected 2", fs_cnt);
    else passed++;
  endtask

  task automatic test_enable();
    int n;
    for (int i = 0; i < 15 && cx != 5; i++) tick_and_check("seek_x5");
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (pe !== 1'b0 || obs0() !== model(5, cy, 1'b0))
        $display("FAIL enable_hold: got %h pix_en=%b expected %h pix_en=0", obs0(), pe, model(5, cy, 1'b0));
      else passed++;
    end
    en = 1'b1;
    tick_and_check("enable_resume");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 150 && !(cx == 9 && cy == 2); i++) tick_and_check("seek_x9y2");
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs0() !== RESET_VEC || pe !== 1'b0)
      $display("FAIL reset_mid: got %h pix_en=%b expected %h pix_en=0", obs0(), pe, RESET_VEC);
    else passed++;
    step();
    rst_n = 1'b1;
    after_release();
  endtask

  task automatic test_div1_pol();
    int x, y;
    en1 = 1'b1;
    step();
    rst1_n = 1'b1;
    for (int i = 0; i < 240; i++) begin
      step();
      x = i % 15;
      y = (i / 15) % 8;
      checks++;
      if (pe1 !== 1'b1 || obs1() !== model(x, y, 1'b1))
        $display("FAIL div1_pol: got %h pix_en=%b expected %h pix_en=1", obs1(), pe1, model(x, y, 1'b1));
      else passed++;
    end
  endtask

  initial begin
    rst1_n = 1'b0;
    en1    = 1'b0;
    test_reset();
    test_line();
    test_frames();
    test_enable();
    test_reset_mid();
    test_div1_pol();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
